// File: rtl/tart_vis_prefetch.sv
// Visibility prefetch sequencer: on a bank-swap pulse, reads every visibility
// word of every correlator block over the read bus and copies it into the
// host readback RAM, then flags the set as available to the host.
module tart_vis_prefetch #(
   parameter int ACCUM   = 32,
   parameter int ABITS   = 10,
   parameter int BLOCKS  = 6,
   parameter int WORDS   = 128,
   parameter int RBITS   = 10,
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             enable,
   input  logic             switch,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic             bst_o,
   output logic [ABITS-1:0] adr_o,
   input  logic             ack_i,
   input  logic [ACCUM-1:0] dat_i,
   output logic             ram_we_o,
   output logic [RBITS-1:0] ram_adr_o,
   output logic [ACCUM-1:0] ram_dat_o,
   output logic             available_o,
   input  logic             vis_ack_i,
   output logic             busy_o,
   output logic             overrun_o,
   output logic             timeout_o,
   input  logic             clear_i
);

   localparam int WBITS = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int BBITS = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
   localparam int TBITS = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WBITS-1:0] word;
   logic [BBITS-1:0] blk;
   logic [TBITS-1:0] tcnt;
   logic             pending;

   logic             last_word;
   logic             last_blk;
   logic             start;
   logic             abort;
   logic             accepted;
   logic             word_ack;
   logic [RBITS-1:0] ram_idx;

   assign last_word = (word == WBITS'(WORDS - 1));
   assign last_blk  = (blk == BBITS'(BLOCKS - 1));
   assign accepted  = switch & enable;
   assign start     = (state == IDLE) & (switch | pending) & enable;
   assign word_ack  = (state == READ) & ack_i;
   // An ack on the final allowed cycle still counts as a good read.
   assign abort     = (state == READ) & ~ack_i & (tcnt == TBITS'(TIMEOUT - 1));

   assign adr_o   = ABITS'({blk, word});
   assign ram_idx = RBITS'(blk) * RBITS'(WORDS) + RBITS'(word);
   assign we_o    = 1'b0;
   assign busy_o  = (state != IDLE);

   // State register.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and bus strobes; strobes decode straight from the state so reset clears them at once.
   always_comb begin
      state_nx = state;
      cyc_o    = 1'b0;
      stb_o    = 1'b0;
      bst_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = READ;
         end
         READ: begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
            bst_o = ~last_word;
            if (ack_i) begin
               if (last_word && last_blk) state_nx = DONE;
               else                       state_nx = GAP;
            end else if (abort) begin
               state_nx = IDLE;
            end
         end
         GAP: begin
            cyc_o    = 1'b1;
            state_nx = READ;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Word/block sweep counters and the per-READ ack watchdog.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         word <= '0;
         blk  <= '0;
         tcnt <= '0;
      end else begin
         if (state == GAP) begin
            if (last_word) begin
               word <= '0;
               blk  <= blk + BBITS'(1);
            end else begin
               word <= word + WBITS'(1);
            end
         end else if (state == DONE || abort) begin
            word <= '0;
            blk  <= '0;
         end
         if (state != READ)  tcnt <= '0;
         else if (!ack_i)    tcnt <= tcnt + TBITS'(1);
      end
   end

   // Capture each acknowledged word into the readback RAM one cycle later.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         ram_we_o  <= 1'b0;
         ram_adr_o <= '0;
         ram_dat_o <= '0;
      end else begin
         ram_we_o <= word_ack;
         if (word_ack) begin
            ram_adr_o <= ram_idx;
            ram_dat_o <= dat_i;
         end
      end
   end

   // Pending sweep request: a swap during a sweep is queued once; an aborted sweep drops it.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst)                               pending <= 1'b0;
      else if (abort)                        pending <= 1'b0;
      else if (accepted && state != IDLE)    pending <= 1'b1;
      else if (start)                        pending <= 1'b0;
   end

   // Host-visible status flags; a new event wins over a simultaneous clear or consume.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         available_o <= 1'b0;
         overrun_o   <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         if (state == DONE)             available_o <= 1'b1;
         else if (start || vis_ack_i)   available_o <= 1'b0;

         if (accepted && (state != IDLE || (available_o && !vis_ack_i)))
            overrun_o <= 1'b1;
         else if (clear_i)
            overrun_o <= 1'b0;

         if (abort)        timeout_o <= 1'b1;
         else if (clear_i) timeout_o <= 1'b0;
      end
   end

endmodule
